// File: rtl/demux_ctrl_pkg.sv
// Shared types and helpers for the 1-to-4 stream demux controller.
package demux_ctrl_pkg;

  localparam int NUM_DEST = 4;
  localparam int SEL_W    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [NUM_DEST-1:0] onehot4(input logic [SEL_W-1:0] sel);
    return NUM_DEST'(1) << sel;
  endfunction

endpackage

// File: rtl/demux_sat_counter.sv
// Event counter that either wraps or saturates at all-ones, selected by sat_en.
module demux_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         sat_en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !(sat_en && (count == '1))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/demux_stream_ctrl.sv
// Valid/ready controller holding one beat and presenting it to one of four
// destinations; beats for disabled destinations are dropped and counted.
module demux_stream_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int DW   = 8,
  parameter int CNTW = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [NUM_DEST-1:0]    en_mask,
  output logic [NUM_DEST-1:0]    out_valid,
  input  logic [NUM_DEST-1:0]    out_ready,
  output logic [DW-1:0]          out_data,
  output logic                   busy,
  output logic                   drop_pulse,
  output logic [NUM_DEST*CNTW-1:0] xfer_cnt,
  output logic [CNTW-1:0]        drop_cnt
);

  state_t           state_q, state_d;
  logic [DW-1:0]    data_q;
  logic [SEL_W-1:0] sel_q;
  logic             accept;
  logic             load;
  logic             drop;
  logic             xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      sel_q      <= '0;
      drop_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_pulse <= drop;
      if (load) begin
        data_q <= in_data;
        sel_q  <= in_sel;
      end
    end
  end

  // A completing transfer frees the slot in the same cycle, so a new beat
  // may load (or be dropped) on the very edge the held one leaves.
  always_comb begin
    state_d   = state_q;
    out_valid = '0;
    out_data  = '0;
    busy      = 1'b0;
    xfer      = 1'b0;
    in_ready  = (state_q == IDLE) || out_ready[sel_q];
    accept    = in_valid && in_ready;
    load      = accept && en_mask[in_sel];
    drop      = accept && !en_mask[in_sel];

    if (state_q == HOLD) begin
      out_valid = onehot4(sel_q);
      out_data  = data_q;
      busy      = 1'b1;
      xfer      = out_ready[sel_q];
      if (xfer) state_d = IDLE;
    end
    if (load) state_d = HOLD;
  end

  demux_sat_counter #(.W(CNTW)) u_drop_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (drop),
    .sat_en (1'b1),
    .count  (drop_cnt)
  );

  for (genvar i = 0; i < NUM_DEST; i++) begin : g_xfer
    demux_sat_counter #(.W(CNTW)) u_xfer_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (xfer && (sel_q == SEL_W'(i))),
      .sat_en (1'b0),
      .count  (xfer_cnt[i*CNTW +: CNTW])
    );
  end

endmodule

// File: tb/tb_demux_stream_ctrl.sv
// Scoreboard bench for demux_stream_ctrl: accepted beats are queued by the
// driver and popped when a destination handshake completes.
module tb_demux_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  en_mask;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        drop_pulse;
  logic [31:0] xfer_cnt;
  logic [7:0]  drop_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [9:0]  sb[$];
  logic [9:0]  exp_item;
  logic [7:0]  exp_xfer[4];
  logic [7:0]  exp_drop;

  always #5 clk = ~clk;

  demux_stream_ctrl #(.DW(8), .CNTW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .en_mask    (en_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .drop_pulse (drop_pulse),
    .xfer_cnt   (xfer_cnt),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] xc(input int unsigned i);
    return xfer_cnt[i*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    for (int unsigned i = 0; i < 4; i++) exp_xfer[i] = '0;
    exp_drop = '0;
  endtask

  // Holds in_valid until the handshake happens; returns 1ns after the accepting edge.
  task automatic send(input logic [1:0] s, input logic [7:0] d, input logic [3:0] m);
    bit done = 0;
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    en_mask  = m;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        if (m[s]) sb.push_back({s, d});
        else if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
      end
      tick();
    end
    if (!done) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && ((out_valid & out_ready) != 4'b0)) begin
      if (sb.size() == 0) begin
        chk("unexpected_xfer", 1, 0);
      end else begin
        exp_item = sb.pop_front();
        chk("out_valid", {60'b0, out_valid}, {60'b0, 4'b0001 << exp_item[9:8]});
        chk("out_data", {56'b0, out_data}, {56'b0, exp_item[7:0]});
        exp_xfer[exp_item[9:8]] = exp_xfer[exp_item[9:8]] + 8'd1;
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    en_mask   = 4'hF;
    out_ready = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_drop_pulse", drop_pulse, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single beat, one-cycle latency
    out_ready = 4'h4;
    send(2'd2, 8'hA5, 4'hF);
    chk("lat_out_valid", out_valid, 4'b0100);
    chk("lat_out_data", out_data, 8'hA5);
    tick();
    chk("single_xfer2", xc(2), exp_xfer[2]);
    chk("single_busy", busy, 0);

    // stall with foreign ready lines asserted
    out_ready = 4'b1101;
    send(2'd1, 8'h5A, 4'hF);
    for (int unsigned k = 0; k < 5; k++) begin
      chk("stall_valid", out_valid, 4'b0010);
      chk("stall_data", out_data, 8'h5A);
      chk("stall_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 4'b0010;
    #1;
    chk("release_in_ready", in_ready, 1);
    tick();
    chk("release_busy", busy, 0);
    chk("release_xfer1", xc(1), exp_xfer[1]);

    // back-to-back stream
    out_ready = 4'h8;
    for (int unsigned k = 0; k < 4; k++) begin
      send(2'd3, 8'h30 + 8'(k), 4'hF);
      chk("stream_busy", busy, 1);
    end
    tick();
    chk("stream_xfer3", xc(3), 8'd4);
    chk("stream_xfer3_model", xc(3), exp_xfer[3]);
    chk("stream_idle", busy, 0);

    // transfer completes and disabled beat drops on the same edge
    out_ready = 4'h2;
    send(2'd1, 8'h11, 4'hF);
    send(2'd0, 8'h22, 4'b1110);
    chk("mixed_busy", busy, 0);
    chk("mixed_pulse", drop_pulse, 1);
    chk("mixed_drop_cnt", drop_cnt, exp_drop);
    chk("mixed_xfer1", xc(1), exp_xfer[1]);
    tick();
    chk("mixed_pulse_end", drop_pulse, 0);

    // drops from idle, up to saturation
    out_ready = 4'h0;
    send(2'd0, 8'h99, 4'b1110);
    chk("drop_valid", out_valid, 0);
    chk("drop_pulse", drop_pulse, 1);
    chk("drop_cnt2", drop_cnt, 8'd2);
    tick();
    chk("drop_pulse_end", drop_pulse, 0);
    for (int unsigned k = 0; k < 299; k++) send(2'd0, 8'(k), 4'b1110);
    tick();
    chk("drop_sat", drop_cnt, 8'hFF);
    chk("drop_sat_model", drop_cnt, exp_drop);

    // mask cleared while held does not affect delivery
    send(2'd1, 8'hC3, 4'hF);
    en_mask = 4'b1101;
    tick();
    tick();
    chk("mask_hold_valid", out_valid, 4'b0010);
    out_ready = 4'h2;
    tick();
    chk("mask_xfer1", xc(1), exp_xfer[1]);
    chk("mask_drop_cnt", drop_cnt, 8'hFF);
    chk("mask_busy", busy, 0);

    // asynchronous reset mid-hold
    out_ready = 4'h0;
    send(2'd2, 8'h77, 4'hF);
    chk("prerst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_xfer_cnt", xfer_cnt, 0);
    chk("arst_drop_cnt", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 4'hF;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
